// File: rtl/xnor_serial_matcher_pkg.sv
// Shared definitions for the serial XNOR word matcher: FSM state encodings and default word width.
package xnor_serial_matcher_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/xnor_bit_counter.sv
// Bit-position counter for one serial word, with synchronous clear, enable and a last-bit flag.
module xnor_bit_counter #(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned IW    = $clog2(WIDTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clear,
    input  logic          i_en,
    output logic [IW-1:0] o_count,
    output logic          o_at_last
);

    localparam logic [IW-1:0] LastIdx = IW'(WIDTH - 1);

    logic [IW-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + IW'(1);
        end
    end

    assign o_count   = r_count;
    assign o_at_last = (r_count == LastIdx);

endmodule

// File: rtl/xnor_gate.sv
// Two-input XNOR gate; o_c is 1 when the inputs are equal.
module xnor_gate (
    input  logic i_a,
    input  logic i_b,
    output logic o_c
);

    assign o_c = ~(i_a ^ i_b);

endmodule

// File: rtl/xnor_serial_matcher.sv
// Collects WIDTH serial equality bits per word and reports match / mismatch count.
// Define XNOR_MATCHER_FIRST_IDX_EN to capture the index of the first mismatching bit.
module xnor_serial_matcher
    import xnor_serial_matcher_pkg::*;
#(
    parameter  int unsigned WIDTH = DefaultWidth,
    localparam int unsigned CW    = $clog2(WIDTH + 1),
    localparam int unsigned IW    = $clog2(WIDTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic          i_bit_valid,
    input  logic          i_eq_bit,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_match,
    output logic [CW-1:0] o_mismatch_count,
    output logic [IW-1:0] o_first_idx
);

    state_e        r_state, w_state_d;
    logic [CW-1:0] r_acc_mm, r_mm_count, w_mm_next;
    logic          r_acc_match, r_match, w_match_next;
    logic [IW-1:0] w_count;
    logic          w_at_last, w_accept, w_abort_run, w_bit_take;

    // abort outranks start and bit_valid in every state
    assign w_accept    = !i_abort && i_start && (r_state == StIdle || r_state == StDone);
    assign w_abort_run = i_abort && (r_state == StRun);
    assign w_bit_take  = !i_abort && i_bit_valid && (r_state == StRun);

    assign w_mm_next    = r_acc_mm + {{(CW-1){1'b0}}, ~i_eq_bit};
    assign w_match_next = r_acc_match & i_eq_bit;

    xnor_bit_counter #(
        .WIDTH(WIDTH)
    ) u_counter (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (w_accept || w_abort_run),
        .i_en     (w_bit_take),
        .o_count  (w_count),
        .o_at_last(w_at_last)
    );

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: if (w_accept) w_state_d = StRun;
            StRun: begin
                if (i_abort) begin
                    w_state_d = StIdle;
                end else if (w_bit_take && w_at_last) begin
                    w_state_d = StDone;
                end
            end
            StDone:  w_state_d = w_accept ? StRun : StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_acc_mm    <= '0;
            r_acc_match <= 1'b0;
            r_match     <= 1'b0;
            r_mm_count  <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_accept) begin
                r_acc_mm    <= '0;
                r_acc_match <= 1'b1;
                r_match     <= 1'b0;
                r_mm_count  <= '0;
            end else if (w_abort_run) begin
                r_match    <= 1'b0;
                r_mm_count <= '0;
            end else if (w_bit_take) begin
                r_acc_mm    <= w_mm_next;
                r_acc_match <= w_match_next;
                if (w_at_last) begin
                    r_match    <= w_match_next;
                    r_mm_count <= w_mm_next;
                end
            end
        end
    end

`ifdef XNOR_MATCHER_FIRST_IDX_EN
    logic          r_found;
    logic [IW-1:0] r_first_acc, r_first_idx, w_first_next;

    // a word with no zero bit reports index 0
    assign w_first_next = r_found ? r_first_acc : (i_eq_bit ? '0 : w_count);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_found     <= 1'b0;
            r_first_acc <= '0;
            r_first_idx <= '0;
        end else if (w_accept || w_abort_run) begin
            r_found     <= 1'b0;
            r_first_acc <= '0;
            r_first_idx <= '0;
        end else if (w_bit_take) begin
            if (!r_found && !i_eq_bit) begin
                r_found     <= 1'b1;
                r_first_acc <= w_count;
            end
            if (w_at_last) begin
                r_first_idx <= w_first_next;
            end
        end
    end

    assign o_first_idx = r_first_idx;
`else
    logic w_unused_count;
    assign w_unused_count = ^w_count;
    assign o_first_idx    = '0;
`endif

    assign o_busy           = (r_state == StRun);
    assign o_done           = (r_state == StDone);
    assign o_match          = r_match;
    assign o_mismatch_count = r_mm_count;

endmodule

// File: tb/tb_xnor_serial_matcher.sv
// Directed bench: xnor_gate drives the matcher's eq_bit; checks with immediate assertions.
module tb_xnor_serial_matcher;
    import xnor_serial_matcher_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = $clog2(W + 1);
    localparam int unsigned IW = $clog2(W);
`ifdef XNOR_MATCHER_FIRST_IDX_EN
    localparam bit FiEn = 1'b1;
`else
    localparam bit FiEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n, start, abort, bit_valid, a, b;
    logic          eq, busy, done, match;
    logic [CW-1:0] mm_count;
    logic [IW-1:0] first_idx;
    int            n_tests = 0;
    int            n_fail  = 0;

    always #5 clk = ~clk;

    xnor_gate u_gate (
        .i_a(a),
        .i_b(b),
        .o_c(eq)
    );

    xnor_serial_matcher #(
        .WIDTH(W)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_start         (start),
        .i_abort         (abort),
        .i_bit_valid     (bit_valid),
        .i_eq_bit        (eq),
        .o_busy          (busy),
        .o_done          (done),
        .o_match         (match),
        .o_mismatch_count(mm_count),
        .o_first_idx     (first_idx)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("start_busy", busy, 1);
    endtask

    // Feeds one word; stall_mask[i] inserts a bit_valid=0 cycle after serial bit i.
    task automatic send_word(input logic [7:0] wa, input logic [7:0] wb, input bit msb_first,
                             input logic [7:0] stall_mask);
        int idx;
        for (int i = 0; i < 8; i++) begin
            idx       = msb_first ? 7 - i : i;
            a         = wa[idx];
            b         = wb[idx];
            bit_valid = 1'b1;
            cycle();
            if (i < 7) begin
                chk("done_early", done, 0);
                if (stall_mask[i]) begin
                    bit_valid = 1'b0;
                    cycle();
                    chk("stall_busy", busy, 1);
                    chk("stall_done", done, 0);
                end
            end
        end
        bit_valid = 1'b0;
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; bit_valid = 1'b0; a = 1'b0; b = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        repeat (5) cycle();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_match", match, 0);
        chk("rst_mm", mm_count, 0);
        chk("rst_first", first_idx, 0);

        // equal words
        do_start();
        send_word(8'hA5, 8'hA5, 1'b0, 8'h00);
        chk("eq_match", match, 1);
        chk("eq_mm", mm_count, 0);
        chk("eq_first", first_idx, 0);
        cycle();
        chk("eq_one_pulse", done, 0);
        chk("eq_idle", busy, 0);
        chk("eq_hold", match, 1);

        // unequal, LSB first, with three stalls; start clears held match
        do_start();
        chk("start_clr_match", match, 0);
        send_word(8'hFF, 8'hF0, 1'b0, 8'b0010_1010);
        chk("ne_lsb_match", match, 0);
        chk("ne_lsb_mm", mm_count, 4);
        chk("ne_lsb_first", first_idx, 0);
        cycle();

        // same word, MSB first
        do_start();
        send_word(8'hFF, 8'hF0, 1'b1, 8'b0000_0100);
        chk("ne_msb_match", match, 0);
        chk("ne_msb_mm", mm_count, 4);
        chk("ne_msb_first", first_idx, FiEn ? 4 : 0);
        cycle();

        // abort after four valid bits, with bit_valid also high
        do_start();
        for (int i = 0; i < 4; i++) begin
            a = 1'b1; b = 1'b0; bit_valid = 1'b1;
            cycle();
        end
        abort = 1'b1;
        cycle();
        abort = 1'b0; bit_valid = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_match", match, 0);
        chk("abort_mm", mm_count, 0);
        chk("abort_first", first_idx, 0);
        cycle();
        chk("abort_no_pulse", done, 0);
        do_start();
        send_word(8'h3C, 8'h3C, 1'b0, 8'h00);
        chk("post_abort_match", match, 1);
        chk("post_abort_mm", mm_count, 0);

        // back-to-back: start during the DONE cycle
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("b2b_busy", busy, 1);
        chk("b2b_done", done, 0);
        send_word(8'h5A, 8'h7A, 1'b0, 8'h00);
        chk("b2b_match", match, 0);
        chk("b2b_mm", mm_count, 1);
        chk("b2b_first", first_idx, FiEn ? 5 : 0);
        cycle();

        // start and abort together in IDLE: abort wins
        start = 1'b1; abort = 1'b1;
        cycle();
        start = 1'b0; abort = 1'b0;
        chk("sa_idle", busy, 0);
        chk("sa_hold_mm", mm_count, 1);

        // async reset mid-word, between clock edges
        do_start();
        for (int i = 0; i < 5; i++) begin
            a = 1'b0; b = 1'b1; bit_valid = 1'b1;
            cycle();
        end
        bit_valid = 1'b0;
        chk("pre_rst_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_match", match, 0);
        chk("arst_mm", mm_count, 0);
        chk("arst_first", first_idx, 0);
        cycle();
        rst_n = 1'b1;
        cycle();
        cycle();
        chk("arst_idle", busy, 0);
        chk("arst_idle_done", done, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/xnor_serial_matcher.md
Name: xnor_serial_matcher

Overview:
- Downstream consumer of the xnor_gate output.
- Per clock, the gate's c output is one equality bit (1 = bits equal) of two bit-serial words driven on its a/b inputs.
- This block collects WIDTH such bits per word and reports a whole-word match, the mismatch count, and optionally the first mismatching bit index.
- It closes the loop for serial word comparison built on the 2-input gate library.

Parameters:
- WIDTH, 8: bits per compared word; legal range 2..64.
- CW, $clog2(WIDTH+1): width of mismatch_count (localparam, not overridable).
- IW, $clog2(WIDTH): width of first_idx (localparam, not overridable).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a new word comparison; accepted in IDLE or DONE only.
- abort  input  1  cancel the word in progress; returns to IDLE.
- bit_valid  input  1  eq_bit is valid this cycle.
- eq_bit  input  1  equality bit, connected to xnor_gate c.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when a word completes.
- match  output  1  1 if all WIDTH bits were equal; held until the next start.
- mismatch_count  output  CW  number of zero eq_bits in the last word; held.
- first_idx  output  IW  index of the first zero eq_bit (see Optional Feature).

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, bit counter=0; busy=0, done=0, match=0, mismatch_count=0, first_idx=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - bit_valid ignored.
  - start=1 -> RUN next cycle; counter=0, mismatch accumulator=0, match accumulator=1.
  - match and mismatch_count keep their previous word's values until the start edge, then clear.
- RUN:
  - busy=1.
  - On each cycle with bit_valid=1: counter+1; if eq_bit=0, mismatch accumulator+1 and match accumulator cleared.
  - bit_valid=0 cycles stall with no state change; no timeout.
  - On the WIDTH-th valid bit (counter==WIDTH-1 with bit_valid=1) -> DONE; match and mismatch_count registered from the accumulators including that bit.
  - start is ignored in RUN.
- DONE:
  - Lasts exactly one cycle: done=1, busy=0.
  - Then -> IDLE, unless start=1 in that cycle, in which case -> RUN directly (back-to-back words, no idle gap).
- Latency: done rises on the clock edge that samples the last valid bit; it is visible the cycle after that bit is presented.
- abort:
  - Has priority over start and bit_valid in any state.
  - In RUN: -> IDLE next cycle; done not pulsed; match=0, mismatch_count=0.
  - In IDLE or DONE: no effect except suppressing start.
- Simultaneous start and abort: abort wins.
- Width rules:
  - mismatch_count saturation is unnecessary, since the maximum is WIDTH and CW holds it.
  - The counter never wraps within a word; it is reset on every accepted start.
- Reset mid-RUN: immediate return to reset values; a partial word is discarded silently.

Optional Feature:
- Macro: XNOR_MATCHER_FIRST_IDX_EN.
- Defined:
  - first_idx captures the counter value of the first valid bit with eq_bit=0 in the word.
  - It is registered on the DONE transition and held until the next accepted start.
  - If match=1, first_idx=0.
  - abort clears it to 0.
- Undefined:
  - first_idx is tied to 0 and no capture register is synthesized.
  - The port remains so integration is unchanged.

Decomposition:
- Shared header xnor_matcher_defs.vh:
  - state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - default WIDTH.
- Include the header in both RTL and bench.
- One natural sub-module: xnor_bit_counter, holding the counter with clear/enable and an at-last flag (counter==WIDTH-1).
- FSM and accumulators stay in the top module.
- The bench instantiates xnor_gate feeding eq_bit, so the pair is exercised as a chain.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles, release, 5 idle cycles -> busy=0, done=0, match=0, mismatch_count=0, first_idx=0.
- Equal words, WIDTH=8: start, then gate inputs a=b=8'hA5 serially with bit_valid=1 on 8 consecutive cycles -> done pulses once after bit 7; match=1, mismatch_count=0.
- Unequal words with stalls: a=8'hFF, b=8'hF0, with bit_valid=0 on 3 interleaved cycles:
  - always: match=0, mismatch_count=4; done occurs only after the 8th valid bit.
  - with macro and LSB-first order: first_idx=0.
  - with macro and MSB-first order: first_idx=4.
- Abort mid-word: start, 4 valid bits, abort=1 -> IDLE next cycle, no done pulse, match=0, mismatch_count=0; then a fresh start completes normally.
- Back-to-back words: start asserted during the DONE cycle -> RUN the next cycle with no IDLE gap; the second word (one mismatch) yields match=0, mismatch_count=1.
- Async reset during RUN: drop rst_n between clock edges after 5 valid bits -> all outputs 0 immediately, not waiting for the clock; state=IDLE after release.
